// File: rtl/rat_pkg.sv
// Shared RAT types: the saved flag pair and the default shadow-stack depth.
package rat_pkg;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  localparam int SHAD_DEPTH_DEF = 4;

endpackage

// File: rtl/flag_lifo_mem.sv
// Flag-pair storage for the shadow stack: synchronous write, asynchronous read.
module flag_lifo_mem
  import rat_pkg::*;
#(
  parameter int DEPTH = SHAD_DEPTH_DEF,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  flags_t           i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output flags_t           o_rdata
);

  flags_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/flag_shadow_stack.sv
// LIFO of C/Z flag pairs saved on interrupt entry and restored on RETIE/RETID.
module flag_shadow_stack
  import rat_pkg::*;
#(
  parameter int DEPTH = SHAD_DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             C_FLAG,
  input  logic             Z_FLAG,
  input  logic             SHAD_PUSH,
  input  logic             SHAD_POP,
  input  logic             ERR_CLR,
  output logic             SHAD_C,
  output logic             SHAD_Z,
  output logic             RESTORE_VLD,
  output logic [PTR_W-1:0] LEVEL,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF_ERR,
  output logic             UNF_ERR
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LVL_MAX = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LVL_ONE = PTR_W'(1);

  logic [PTR_W-1:0] r_level;
  flags_t           r_shad;
  logic             r_vld;
  logic             r_ovf;
  logic             r_unf;

  logic [PTR_W-1:0] w_level_m1;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic             w_push_ok;
  logic             w_we;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic [IDX_W-1:0] w_waddr;
  logic [IDX_W-1:0] w_raddr;
  flags_t           w_live;
  flags_t           w_top;

  assign w_level_m1 = r_level - LVL_ONE;
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_MAX);
  assign w_live     = {C_FLAG, Z_FLAG};

  // A same-cycle pop frees the top slot, so a push alongside a pop never overflows.
  assign w_pop_ok  = SHAD_POP && !w_empty;
  assign w_push_ok = SHAD_PUSH && (SHAD_POP || !w_full);
  assign w_we      = w_push_ok && RST_N;
  assign w_ovf_set = SHAD_PUSH && !SHAD_POP && w_full;
  assign w_unf_set = SHAD_POP && w_empty;

  // Push+pop overwrites the popped slot in place; otherwise push goes to the next free slot.
  assign w_waddr = w_pop_ok ? IDX_W'(w_level_m1) : IDX_W'(r_level);
  assign w_raddr = w_empty ? '0 : IDX_W'(w_level_m1);

  flag_lifo_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_live),
    .i_raddr (w_raddr),
    .o_rdata (w_top)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_level <= '0;
      r_shad  <= '0;
      r_vld   <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_vld <= w_pop_ok;
      if (w_pop_ok) begin
        r_shad <= w_top;
      end
      if (w_pop_ok && !SHAD_PUSH) begin
        r_level <= w_level_m1;
      end else if (SHAD_PUSH && !SHAD_POP && !w_full) begin
        r_level <= r_level + LVL_ONE;
      end else if (SHAD_PUSH && SHAD_POP && w_empty) begin
        r_level <= LVL_ONE;
      end
      r_ovf <= w_ovf_set || (r_ovf && !ERR_CLR);
      r_unf <= w_unf_set || (r_unf && !ERR_CLR);
    end
  end

  assign LEVEL       = r_level;
  assign EMPTY       = w_empty;
  assign FULL        = w_full;
  assign SHAD_C      = r_shad.c;
  assign SHAD_Z      = r_shad.z;
  assign RESTORE_VLD = r_vld;
  assign OVF_ERR     = r_ovf;
  assign UNF_ERR     = r_unf;

endmodule

// File: tb/tb_flag_shadow_stack.sv
// Bench for flag_shadow_stack: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_flag_shadow_stack;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RST_N, C_FLAG, Z_FLAG, SHAD_PUSH, SHAD_POP, ERR_CLR;
  logic             SHAD_C, SHAD_Z, RESTORE_VLD, EMPTY, FULL, OVF_ERR, UNF_ERR;
  logic [PTR_W-1:0] LEVEL;

  flag_shadow_stack #(
    .DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .C_FLAG      (C_FLAG),
    .Z_FLAG      (Z_FLAG),
    .SHAD_PUSH   (SHAD_PUSH),
    .SHAD_POP    (SHAD_POP),
    .ERR_CLR     (ERR_CLR),
    .SHAD_C      (SHAD_C),
    .SHAD_Z      (SHAD_Z),
    .RESTORE_VLD (RESTORE_VLD),
    .LEVEL       (LEVEL),
    .EMPTY       (EMPTY),
    .FULL        (FULL),
    .OVF_ERR     (OVF_ERR),
    .UNF_ERR     (UNF_ERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: stack of {c,z} pairs plus expected output registers.
  logic [1:0] m_q [$];
  logic       m_c, m_z, m_vld, m_ovf, m_unf;
  bit         chk_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic push, input logic pop,
                              input logic clr, input logic c, input logic z);
    logic [1:0] top;
    bit ovf_new, unf_new;
    ovf_new = 0;
    unf_new = 0;
    if (!rst) begin
      m_q.delete();
      {m_c, m_z, m_vld, m_ovf, m_unf} = '0;
    end else begin
      m_vld = 1'b0;
      if (pop) begin
        if (m_q.size() > 0) begin
          top = m_q.pop_back();
          m_c = top[1];
          m_z = top[0];
          m_vld = 1'b1;
        end else begin
          unf_new = 1;
        end
      end
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back({c, z});
        else ovf_new = 1;
      end
      m_ovf = ovf_new || (m_ovf && !clr);
      m_unf = unf_new || (m_unf && !clr);
    end
  endtask

  // Drive one cycle: inputs set at the falling edge, model follows the rising edge.
  task automatic step(input logic rst, input logic push, input logic pop,
                      input logic clr, input logic c, input logic z);
    RST_N = rst; SHAD_PUSH = push; SHAD_POP = pop; ERR_CLR = clr; C_FLAG = c; Z_FLAG = z;
    @(posedge CLK);
    model_update(rst, push, pop, clr, c, z);
    @(negedge CLK);
  endtask

  task automatic push(input logic c, input logic z);
    step(1'b1, 1'b1, 1'b0, 1'b0, c, z);
  endtask

  task automatic pop();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("LEVEL", int'(LEVEL), m_q.size());
      check("EMPTY", int'(EMPTY), int'(m_q.size() == 0));
      check("FULL", int'(FULL), int'(m_q.size() == DEPTH));
      check("SHAD_C", int'(SHAD_C), int'(m_c));
      check("SHAD_Z", int'(SHAD_Z), int'(m_z));
      check("RESTORE_VLD", int'(RESTORE_VLD), int'(m_vld));
      check("OVF_ERR", int'(OVF_ERR), int'(m_ovf));
      check("UNF_ERR", int'(UNF_ERR), int'(m_unf));
    end
  end

  initial begin
    logic [1:0] pat [5];
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b11; pat[3] = 2'b00; pat[4] = 2'b11;

    @(negedge CLK);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_level", int'(LEVEL), 0);
    check("rst_outs", int'({SHAD_C, SHAD_Z, RESTORE_VLD, OVF_ERR, UNF_ERR}), 0);

    // 1: single push/pop round trip
    push(1'b1, 1'b0);
    check("t1_level", int'(LEVEL), 1);
    pop();
    check("t1_restore", int'({RESTORE_VLD, SHAD_C, SHAD_Z}), 3'b110);
    check("t1_level0", int'(LEVEL), 0);
    idle();
    check("t1_vld_drop", int'({RESTORE_VLD, SHAD_C, SHAD_Z}), 3'b010);

    // 2: LIFO order
    push(1'b1, 1'b1); push(1'b0, 1'b1); push(1'b1, 1'b0);
    pop(); check("t2_pop1", int'({SHAD_C, SHAD_Z}), 2'b10);
    pop(); check("t2_pop2", int'({SHAD_C, SHAD_Z}), 2'b01);
    pop(); check("t2_pop3", int'({SHAD_C, SHAD_Z}), 2'b11);
    check("t2_empty", int'(EMPTY), 1);

    // 3: overflow drops the fifth push
    for (int i = 0; i < 5; i++) push(pat[i][1], pat[i][0]);
    check("t3_full", int'({LEVEL, FULL, OVF_ERR}), {3'd4, 2'b11});
    for (int i = 3; i >= 0; i--) begin
      pop();
      check("t3_pop", int'({SHAD_C, SHAD_Z}), int'(pat[i]));
    end

    // 4: underflow, error clear, clear losing to a new error
    pop();
    check("t4_unf", int'({UNF_ERR, RESTORE_VLD, SHAD_C, SHAD_Z}), 4'b1010);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t4_clr", int'({OVF_ERR, UNF_ERR}), 0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_clr_vs_new", int'(UNF_ERR), 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: push and pop together swap the top
    push(1'b1, 1'b0); push(1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t5_swap", int'({RESTORE_VLD, SHAD_C, SHAD_Z, LEVEL}), {3'b100, 3'd2});
    pop();
    check("t5_next", int'({SHAD_C, SHAD_Z}), 2'b11);
    pop(); pop();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_empty_both", int'({LEVEL, UNF_ERR, RESTORE_VLD}), {3'd1, 2'b10});

    // 6: reset wins over a pop
    push(1'b1, 1'b1); push(1'b1, 1'b1); push(1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_rst", int'({LEVEL, SHAD_C, SHAD_Z, RESTORE_VLD, OVF_ERR, UNF_ERR}), 0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
